// File: rtl/network_run_controller_pkg.sv
// Shared opcode/state encodings and output-path sizing for the network run controller.
package run_controller_config;

    localparam int OP_WIDTH       = 2;
    localparam int OUT_FIFO_DEPTH = 4;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_NOP = 2'd0,
        OP_SPK = 2'd1,
        OP_RUN = 2'd2,
        OP_CLR = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_CLR  = 2'd2
    } state_e;

endpackage

// File: rtl/network_run_controller_out_fifo.sv
// Small synchronous FIFO holding {last, word} results until the sink takes them.
module run_out_fifo
    import run_controller_config::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = OUT_FIFO_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (count_q != CNT_W'(DEPTH));
    assign do_pop   = pop && (count_q != '0);
    assign rd_valid = (count_q != '0);
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/network_run_controller.sv
// Decodes host instructions, steps the network under output credits and
// returns one {last, word} result per step to the sink.
//
// state  | meaning
// S_IDLE | accept and decode instructions
// S_RUN  | issue network steps while credits allow
// S_CLR  | one-cycle network clear pulse
module network_run_controller
    import run_controller_config::*;
#(
    parameter int NUM_INP    = 8,
    parameter int NUM_OUT    = 8,
    parameter int RUN_WIDTH  = 16,
    parameter int DATA_WIDTH = (NUM_INP > RUN_WIDTH) ? NUM_INP : RUN_WIDTH
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [OP_WIDTH-1:0]   instr_op,
    input  logic [DATA_WIDTH-1:0] instr_data,
    output logic                  net_en,
    output logic                  net_clr,
    output logic [NUM_INP-1:0]    net_inp,
    input  logic [NUM_OUT-1:0]    net_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [NUM_OUT-1:0]    out
);

    localparam int CNT_W = $clog2(OUT_FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    state_e               state_q;
    state_e               state_d;
    opcode_e              op;
    logic [NUM_INP-1:0]   pending_q;
    logic [RUN_WIDTH-1:0] remaining_q;
    logic                 first_q;
    logic                 s1_valid_q;
    logic                 s1_last_q;
    logic                 s2_valid_q;
    logic                 s2_last_q;
    logic [NUM_OUT-1:0]   s2_word_q;
    logic [CNT_W-1:0]     fifo_count;
    logic [1:0]           inflight;
    logic [OCC_W-1:0]     occupancy;
    logic                 credit_ok;
    logic                 accept;
    logic                 step_last;
    logic [NUM_INP-1:0]   spk_mask;
    logic [RUN_WIDTH-1:0] run_count;

    assign op        = opcode_e'(instr_op);
    assign spk_mask  = instr_data[NUM_INP-1:0];
    assign run_count = instr_data[RUN_WIDTH-1:0];
    assign inflight  = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};
    // Everything already committed to the output path holds a FIFO slot.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight);
    assign credit_ok = occupancy < OCC_W'(OUT_FIFO_DEPTH);
    assign net_inp   = (net_en && first_q) ? pending_q : '0;

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        accept      = 1'b0;
        net_en      = 1'b0;
        net_clr     = 1'b0;
        step_last   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A clear must not race results still travelling to the FIFO.
                instr_ready = !arst && !(op == OP_CLR && inflight != 2'd0);
                accept      = instr_valid && instr_ready;
                if (accept) begin
                    case (op)
                        OP_RUN:  if (run_count != '0) state_d = S_RUN;
                        OP_CLR:  state_d = S_CLR;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_RUN: begin
                net_en = credit_ok;
                if (net_en && remaining_q == RUN_WIDTH'(1)) begin
                    step_last = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_CLR: begin
                net_clr = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_word_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept && op == OP_SPK) begin
                pending_q <= pending_q | spk_mask;
            end
            if (accept && op == OP_RUN && run_count != '0) begin
                remaining_q <= run_count;
                first_q     <= 1'b1;
            end
            if (net_en) begin
                remaining_q <= remaining_q - RUN_WIDTH'(1);
                first_q     <= 1'b0;
                if (first_q) pending_q <= '0;
            end
            if (net_clr) begin
                pending_q <= '0;
            end
            s1_valid_q <= net_en;
            s1_last_q  <= step_last;
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s2_word_q  <= net_out;
        end
    end

    run_out_fifo #(
        .WIDTH (NUM_OUT + 1),
        .DEPTH (OUT_FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_out_fifo (
        .clk       (clk),
        .arst      (arst),
        .push      (s2_valid_q),
        .push_data ({s2_last_q, s2_word_q}),
        .pop       (out_ready),
        .rd_valid  (out_valid),
        .rd_data   ({out_last, out}),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_network_run_controller.sv
// Self-checking bench: directed scenarios plus randomized instruction traffic
// against a transaction-level model of runs, spikes and result ordering.
module tb_network_run_controller;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [1:0]  instr_op = 2'd0;
    logic [15:0] instr_data = 16'd0;
    logic        net_en;
    logic        net_clr;
    logic [7:0]  net_inp;
    logic [7:0]  net_out = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic [7:0]  out;

    network_run_controller dut (
        .clk         (clk),
        .arst        (arst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_data  (instr_data),
        .net_en      (net_en),
        .net_clr     (net_clr),
        .net_inp     (net_inp),
        .net_out     (net_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .out         (out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: runs and spike snapshots queued at acceptance, one
    // expected {last, word} per issued step, consumed in order by the sink.
    int         runs[$];
    logic [7:0] inps[$];
    logic [8:0] exp_q[$];
    logic [7:0] m_pending = 8'd0;
    int         cur_rem = 0;
    int         steps = 0;
    int         pops = 0;
    bit         clr_due = 1'b0;
    bit         have_next = 1'b0;
    logic [7:0] word_next = 8'd0;
    bit         rand_rdy = 1'b0;
    bit         rdy_fixed = 1'b0;

    // The network's output for a step appears during the following cycle.
    always @(posedge clk) begin
        #1;
        net_out   = have_next ? word_next : 8'($urandom);
        have_next = 1'b0;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    always @(negedge clk) begin
        logic [7:0] exp_inp;
        logic [7:0] w;
        if (arst) begin
            runs.delete();
            inps.delete();
            exp_q.delete();
            m_pending = 8'd0;
            cur_rem   = 0;
            steps     = 0;
            pops      = 0;
            clr_due   = 1'b0;
            have_next = 1'b0;
        end else begin
            if (net_clr || clr_due) check_eq("net_clr", 32'(net_clr), 32'(clr_due));
            clr_due = 1'b0;
            if (instr_valid && instr_ready) begin
                case (instr_op)
                    2'd1: m_pending = m_pending | instr_data[7:0];
                    2'd2: if (instr_data != 16'd0) begin
                        runs.push_back(int'(instr_data));
                        inps.push_back(m_pending);
                        m_pending = 8'd0;
                    end
                    2'd3: begin
                        m_pending = 8'd0;
                        clr_due   = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (net_en) begin
                check_eq("credit", 32'((steps - pops) < 4), 32'd1);
                exp_inp = 8'd0;
                if (cur_rem == 0) begin
                    check_eq("run_pending", 32'(runs.size()), 32'd1);
                    if (runs.size() > 0) begin
                        cur_rem = runs.pop_front();
                        exp_inp = inps.pop_front();
                    end else begin
                        cur_rem = 1;
                    end
                end
                check_eq("net_inp", 32'(net_inp), 32'(exp_inp));
                cur_rem--;
                w = 8'($urandom);
                exp_q.push_back({cur_rem == 0, w});
                steps++;
                word_next = w;
                have_next = 1'b1;
            end else if (net_inp != 8'd0) begin
                check_eq("net_inp_idle", 32'(net_inp), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_eq("out_unexpected", 32'(out_valid), 32'd0);
                else check_eq("out_word", 32'({out_last, out}), 32'(exp_q.pop_front()));
                pops++;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] data, output int waits);
        int n;
        n = 0;
        instr_valid = 1'b1;
        instr_op    = op;
        instr_data  = data;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_ready && n < 500);
        if (!instr_ready) check_eq("send_timeout", 32'(instr_ready), 32'd1);
        waits = n - 1;
        next_cycle();
        instr_valid = 1'b0;
        instr_op    = 2'd0;
        instr_data  = 16'($urandom);
    endtask

    task automatic drain();
        int n;
        rand_rdy  = 1'b0;
        rdy_fixed = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || runs.size() != 0 || cur_rem != 0) && n < 400) begin
            next_cycle();
            n++;
        end
        repeat (3) next_cycle();
        check_eq("drain_empty", 32'(exp_q.size() + runs.size() + cur_rem), 32'd0);
    endtask

    initial begin
        int w;
        int p0;
        int cnt;
        logic [6:0] en_bits;
        logic [6:0] vld_bits;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_outs", 32'({instr_ready, net_en, net_clr, net_inp, out_valid, out_last, out}), 32'd0);
        @(posedge clk);
        #1 arst = 1'b0;
        rdy_fixed = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", 32'(instr_ready), 32'd1);
        next_cycle();

        // SPK 0x05, RUN 3: step pattern and first-output latency
        send(2'd1, 16'h0005, w);
        send(2'd2, 16'd3, w);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            en_bits[k]  = net_en;
            vld_bits[k] = out_valid;
        end
        check_eq("run3_en_pattern", 32'(en_bits), 32'b0000111);
        check_eq("run3_valid_pattern", 32'(vld_bits), 32'b0111000);
        drain();

        // RUN 0 is a no-op, RUN 1 yields one last word
        send(2'd2, 16'd0, w);
        @(negedge clk);
        check_eq("run0_no_step", 32'(net_en), 32'd0);
        check_eq("run0_ready", 32'(instr_ready), 32'd1);
        next_cycle();
        p0 = pops;
        send(2'd2, 16'd1, w);
        drain();
        check_eq("run1_words", 32'(pops - p0), 32'd1);

        // RUN 10 under backpressure: four credits, then stall
        rdy_fixed = 1'b0;
        next_cycle();
        p0 = pops;
        send(2'd2, 16'd10, w);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (net_en) cnt++;
        end
        check_eq("bp_steps", 32'(cnt), 32'd4);
        next_cycle();
        drain();
        check_eq("bp_words", 32'(pops - p0), 32'd10);

        // CLR right after RUN 2 waits for the pipeline to empty
        send(2'd2, 16'd2, w);
        send(2'd3, 16'd0, w);
        check_eq("clr_wait", 32'(w), 32'd4);
        drain();

        // Spike accumulation applies only to the next run's first step
        send(2'd1, 16'h0001, w);
        send(2'd1, 16'hA580, w);
        send(2'd2, 16'd1, w);
        @(negedge clk);
        check_eq("spk_merge", 32'(net_inp), 32'h81);
        next_cycle();
        drain();
        send(2'd2, 16'd1, w);
        @(negedge clk);
        check_eq("spk_consumed", 32'({net_en, net_inp}), 32'h100);
        next_cycle();
        drain();

        // Reset in the middle of RUN 20
        send(2'd2, 16'd20, w);
        repeat (6) next_cycle();
        arst = 1'b1;
        @(negedge clk);
        check_eq("midrst_outs", 32'({instr_ready, net_en, net_clr, net_inp, out_valid, out_last, out}), 32'd0);
        next_cycle();
        arst = 1'b0;
        @(negedge clk);
        check_eq("midrst_ready", 32'(instr_ready), 32'd1);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid || net_en) cnt++;
            @(negedge clk);
        end
        check_eq("midrst_no_stale", 32'(cnt), 32'd0);
        next_cycle();

        // Randomized traffic with random sink backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      send(2'd0, 16'($urandom), w);
            else if (r <= 3) send(2'd1, 16'($urandom), w);
            else if (r <= 7) send(2'd2, 16'($urandom_range(0, 12)), w);
            else             send(2'd3, 16'($urandom), w);
            repeat ($urandom_range(0, 2)) next_cycle();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/network_run_controller.md
# network_run_controller

Sequencing controller that sits between the host instruction stream and the `network` core and its output path. Decodes spike, run and clear instructions, and accumulates spike masks into a pending input vector. Drives the network's step enable and clear, and returns one output word per network step to the sink through a valid/ready interface with `out_last` marking the final step of each run. Backpressure is handled with credits against an internal output FIFO, so the network never steps unless its result has a guaranteed slot.

## Interface

Parameters:
- `NUM_INP`, 8: network input count; width of `net_inp` and of a spike mask.
- `NUM_OUT`, 8: network output count; width of `net_out` and `out`.
- `RUN_WIDTH`, 16: width of a run cycle count.
- `DATA_WIDTH`, max(`NUM_INP`, `RUN_WIDTH`): instruction payload width.

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge.
- `arst` in 1: reset, asynchronous, active-high.
- `instr_valid` in 1: an instruction is offered.
- `instr_ready` out 1: the controller accepts the instruction this cycle.
- `instr_op` in 2: opcode; NOP=0, SPK=1, RUN=2, CLR=3.
- `instr_data` in `DATA_WIDTH`: payload; SPK uses bits [NUM_INP-1:0] as the mask, RUN uses bits [RUN_WIDTH-1:0] as the count.
- `net_en` out 1: network advances one step at the next edge.
- `net_clr` out 1: synchronous clear of network state.
- `net_inp` out `NUM_INP`: spike vector applied with `net_en`.
- `net_out` in `NUM_OUT`: network output, valid the cycle after a step.
- `out_valid` out 1: an output word is presented.
- `out_ready` in 1: the sink accepts the output word.
- `out_last` out 1: the presented word is the final step of its run.
- `out` out `NUM_OUT`: output word.

## Operation

- States:
  - IDLE: `instr_ready`=1; all instructions are decoded here.
  - RUN: steps the network; `instr_ready`=0.
  - CLR: one-cycle clear pulse; `instr_ready`=0.
- Instruction handling in IDLE (accepted on `instr_valid && instr_ready`):
  - NOP: no effect.
  - SPK: `pending <= pending | mask`. Multiple SPKs accumulate.
  - RUN with count 0: no-op; `pending` is kept.
  - RUN with count n>0: load `remaining=n`, go to RUN.
  - CLR: go to CLR, but only when `inflight==0`. While `inflight!=0`, `instr_ready` is 0 if `instr_op==CLR`, so the clear waits.
- RUN state:
  - A step is issued (`net_en`=1) when `fifo_count + inflight < 4`.
  - `net_inp = pending` on the first step of the run and 0 on later steps. `pending` clears when the first step is issued.
  - `remaining` decrements on each issued step. The step that takes it from 1 to 0 carries a last tag, and the state returns to IDLE in the next cycle.
- CLR state: `net_clr`=1 for exactly one cycle, `pending` clears, return to IDLE.
- Capture pipeline:
  - A step issued in cycle t tags stage s1 in t+1.
  - In t+1, `net_out` is sampled into stage s2 together with the last tag.
  - s2 is pushed into the FIFO in t+2.
  - `inflight` = number of valid bits in s1 and s2 (0 to 2).
- FIFO: depth 4. It is never overrun because of the credit rule. Its head drives `out`, `out_last` and `out_valid`, and it pops on `out_valid && out_ready`.
- `remaining` never underflows; a RUN count of 2^RUN_WIDTH-1 is legal.

## Timing

- Reset values: `instr_ready`=0 while `arst` is high and 1 in the first cycle after release (IDLE). `net_en`=0, `net_clr`=0, `net_inp`=0, `out_valid`=0, `out_last`=0, `out`=0. FIFO, pipeline, `pending` and `remaining` are all empty or zero.
- `arst` does not pulse `net_clr`; the parent resets the network with the same `arst`.
- Latency:
  - RUN accepted in cycle c, first `net_en` in c+1.
  - First `out_valid` in c+4 (s1 at c+2, s2 at c+3, FIFO head at c+4).
  - Step cadence is 1 per cycle while `out_ready` is held high.
- A RUN of n produces exactly n output words, and only the n-th has `out_last`=1.
- The next RUN may be accepted while the outputs of the previous run are still inflight. Its spikes apply to its own first step.
- `arst` asserted mid-run: all state is dropped immediately; no partial output is produced after release.
- `out_ready` low: issuing stops once `fifo_count + inflight` reaches 4. Nothing is lost, and output order is preserved.

## Structure

- Package `run_controller_config`:
  - opcode enum (NOP, SPK, RUN, CLR)
  - state enum (IDLE, RUN, CLR)
  - `OUT_FIFO_DEPTH`=4
  - opcode width 2
- Sub-module `run_out_fifo`: synchronous FIFO of `{last, word}` entries with push, pop and count outputs, reset by `arst`.

## Test plan

- Reset, then SPK mask 0x05, then RUN 3, with `out_ready`=1:
  - `net_en` high for 3 consecutive cycles.
  - `net_inp`=0x05 on the first step, 0 on the second and third.
  - 3 outputs; `out_last` only on the third; first `out_valid` 4 cycles after RUN acceptance.
- RUN 0, then RUN 1: no step for RUN 0; exactly 1 output with `out_last`=1.
- RUN 10 with `out_ready`=0:
  - exactly 4 `net_en` pulses, then stall.
  - then raise `out_ready`: 10 words total, in order, no duplicates.
- CLR offered immediately after a RUN 2 handshake: `instr_ready` stays low until `inflight`=0, then `net_clr` is a single-cycle pulse.
- SPK 0x01 then SPK 0x80, then RUN 1: `net_inp`=0x81. A following RUN 1 steps with `net_inp`=0.
- `arst` pulsed during a RUN 20: all outputs 0 during reset; `instr_ready`=1 the cycle after release; no stale `out_valid`.
